// File: rtl/mod_mul_unit_pkg.sv
// Shared definitions for the modular multiplier: FSM state encoding and default width.
package mod_mul_unit_pkg;

    localparam int DEFAULT_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MUL    = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/mod_mul_unit_if.sv
// Start/done handshake bundle between a caller (master) and the modular multiplier (slave).
interface mod_mul_unit_if
    import mod_mul_unit_pkg::*;
#(
    parameter int W = DEFAULT_W
);

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] result;
    logic         done;

    modport master (output start, a, b, m, input result, done);
    modport slave  (input start, a, b, m, output result, done);

endinterface

// File: rtl/mod_mul_unit_step.sv
// One MSB-first double-and-add step of modular multiplication; keeps acc < m.
module mod_mul_step
    import mod_mul_unit_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] a_red_i,
    input  logic [W-1:0] m_i,
    input  logic         b_bit_i,
    output logic [W-1:0] acc_o
);

    logic [W+1:0] mWide;
    logic [W+1:0] dbl;
    logic [W+1:0] dblRed;
    logic [W+1:0] sum;

    // Each partial value stays below 2m, so a single conditional subtract restores acc < m.
    always_comb begin
        mWide  = {2'b00, m_i};
        dbl    = {1'b0, acc_i, 1'b0};
        dblRed = (dbl >= mWide) ? (dbl - mWide) : dbl;
        sum    = b_bit_i ? (dblRed + {2'b00, a_red_i}) : dblRed;
        acc_o  = (sum >= mWide) ? W'(sum - mWide) : W'(sum);
    end

endmodule

// File: rtl/mod_mul_unit.sv
// Sequential (a*b) mod m: W cycles reducing a by restoring division, then W multiply steps.
module mod_mul_unit
    import mod_mul_unit_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           reset,
    mod_mul_unit_if.slave  bus
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  result_q, result_d;
    logic          done_q, done_d;

    logic [W:0]    rShift;
    logic [W-1:0]  rNext;
    logic [W-1:0]  accNext;
    logic          lastBit;

    mod_mul_step #(.W(W)) u_step (
        .acc_i   (acc_q),
        .a_red_i (r_q),
        .m_i     (m_q),
        .b_bit_i (b_q[W-1]),
        .acc_o   (accNext)
    );

    // a and b are consumed MSB first by shifting the captured copies left each cycle.
    always_comb begin
        rShift  = {r_q, a_q[W-1]};
        rNext   = (rShift >= {1'b0, m_q}) ? W'(rShift - {1'b0, m_q}) : W'(rShift);
        lastBit = (cnt_q == CW'(W - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        r_d      = r_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    done_d  = 1'b0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    m_d     = bus.m;
                    r_d     = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (bus.m == '0) ? FINISH : REDUCE;
                end else begin
                    done_d = 1'b1;
                end
            end
            REDUCE: begin
                r_d   = rNext;
                a_d   = a_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (lastBit) begin
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = accNext;
                b_d   = b_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (lastBit) begin
                    cnt_d   = '0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_mod_mul_unit.sv
// Scoreboard bench for mod_mul_unit: expected results queued at start, checked when done rises.
module tb_mod_mul_unit;

    localparam int W   = 32;
    localparam int LAT = 2 * W + 1;

    logic clk;
    logic reset;

    mod_mul_unit_if #(.W(W)) bus ();

    mod_mul_unit #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] sbQ[$];
    int          latQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns just after edge E with start already dropped.
    task automatic applyStimulus(input logic [W-1:0] aV, input logic [W-1:0] bV, input logic [W-1:0] mV);
        logic [63:0] prod;
        prod = 64'(aV) * 64'(bV);
        sbQ.push_back((mV == '0) ? 64'd0 : (prod % 64'(mV)));
        latQ.push_back((mV == '0) ? 1 : LAT);
        bus.start = 1'b1;
        bus.a     = aV;
        bus.b     = bV;
        bus.m     = mV;
        tick();
        bus.start = 1'b0;
    endtask

    // Polls done; disturbAt > 0 re-pulses start with fresh operands sampled at edge E+disturbAt.
    task automatic awaitResult(input string tag, input int disturbAt);
        int n;
        int expLat;
        logic [63:0] expRes;
        n = 0;
        checkOutput({tag, "_doneLowAfterE"}, 64'(bus.done), 64'd0);
        while (bus.done !== 1'b1 && n < 200) begin
            if (disturbAt > 0 && n == disturbAt - 1) begin
                bus.start = 1'b1;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
                bus.m     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        if (latQ.size() == 0 || sbQ.size() == 0) begin
            checkOutput({tag, "_scoreboardEmpty"}, 64'd0, 64'd1);
        end else begin
            expLat = latQ.pop_front();
            expRes = sbQ.pop_front();
            checkOutput({tag, "_latency"}, 64'(n), 64'(expLat));
            checkOutput({tag, "_result"}, 64'(bus.result), expRes);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb, rm;
        int n;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.m     = '0;
        reset     = 1'b1;
        tick();
        tick();
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        checkOutput("resetResult", 64'(bus.result), 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("firstIdleDone", 64'(bus.done), 64'd1);

        applyStimulus(32'd7, 32'd9, 32'd10);
        awaitResult("basic", 0);
        tick();
        tick();
        tick();
        checkOutput("resultHold", 64'(bus.result), 64'd3);
        checkOutput("doneHold", 64'(bus.done), 64'd1);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        awaitResult("maxOperands", 0);
        checkOutput("maxOperandsValue", 64'(bus.result), 64'd16);

        applyStimulus(32'd123, 32'd456, 32'd0);
        awaitResult("modZero", 0);

        applyStimulus(32'd5, 32'd0, 32'd13);
        awaitResult("bZero", 0);
        applyStimulus(32'd12, 32'd12, 32'd13);
        awaitResult("backToBack", 0);

        applyStimulus(32'd9, 32'd7, 32'd1);
        awaitResult("modOne", 0);

        applyStimulus(32'd7, 32'd9, 32'd10);
        awaitResult("ignoreStart", 10);
        tick();
        checkOutput("noQueuedJob", 64'(bus.done), 64'd1);

        // Abort a job with reset at E+40 and confirm recovery.
        applyStimulus(32'd7, 32'd9, 32'd10);
        n = 0;
        while (n < 39) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        checkOutput("abortDone", 64'(bus.done), 64'd0);
        checkOutput("abortResult", 64'(bus.result), 64'd0);
        reset = 1'b0;
        void'(sbQ.pop_front());
        void'(latQ.pop_front());
        tick();
        checkOutput("abortRecoverDone", 64'(bus.done), 64'd1);
        applyStimulus(32'd3, 32'd4, 32'd5);
        awaitResult("afterAbort", 0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom();
            rb = $urandom();
            rm = $urandom();
            if (rm == '0) rm = 32'd97;
            applyStimulus(ra, rb, rm);
            awaitResult($sformatf("random%0d", i), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
